// File: rtl/syscall_input_unit.sv
// syscall_input_unit: buffers console input bytes and services read_char / read_int syscalls,
// stalling the pipeline until a 32-bit result is ready for write-back.
module syscall_input_unit #(
    parameter int          FIFO_DEPTH        = 8,
    parameter logic [31:0] SYSCALL_READ_INT  = 32'd5,
    parameter logic [31:0] SYSCALL_READ_CHAR = 32'd12
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        is_syscall,
    input  logic [31:0] syscall_funct,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        stall,
    output logic        result_valid,
    output logic [31:0] result,
    output logic        parse_error
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, CHAR, INT_START, INT_DIGITS, DONE} state_t;

    state_t      state, state_n;
    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic [31:0] acc, acc_n, result_n, digit;
    logic [7:0]  head;
    logic        neg, neg_n, err, err_n, pop, push, empty;
    logic        is_read, is_digit, is_space;

    assign empty    = count == '0;
    assign in_ready = (count != (AW+1)'(FIFO_DEPTH)) && !reset;
    assign push     = in_valid && in_ready;
    assign head     = mem[rd_ptr];
    // ASCII digits 0x30..0x39 carry their value in the low nibble
    assign digit    = {28'd0, head[3:0]};
    assign is_digit = head >= 8'h30 && head <= 8'h39;
    assign is_space = head == 8'h20 || head == 8'h09 || head == 8'h0A || head == 8'h0D;
    assign is_read  = is_syscall && (syscall_funct == SYSCALL_READ_INT || syscall_funct == SYSCALL_READ_CHAR);

    assign stall        = !reset && ((state == IDLE && is_read) || state == CHAR ||
                                     state == INT_START || state == INT_DIGITS);
    assign result_valid = !reset && state == DONE;
    assign parse_error  = result_valid && err;

    always_comb begin
        state_n  = state;
        acc_n    = acc;
        neg_n    = neg;
        err_n    = err;
        result_n = result;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                if (is_syscall && syscall_funct == SYSCALL_READ_CHAR) begin
                    state_n = CHAR;
                end else if (is_syscall && syscall_funct == SYSCALL_READ_INT) begin
                    acc_n   = '0;
                    neg_n   = 1'b0;
                    state_n = INT_START;
                end
            end
            CHAR: begin
                if (!empty) begin
                    pop      = 1'b1;
                    result_n = {24'd0, head};
                    state_n  = DONE;
                end
            end
            INT_START: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (is_digit) begin
                        acc_n   = digit;
                        state_n = INT_DIGITS;
                    end else if (head == 8'h2D) begin
                        neg_n   = 1'b1;
                        state_n = INT_DIGITS;
                    end else if (head == 8'h2B) begin
                        state_n = INT_DIGITS;
                    end else if (!is_space) begin
                        result_n = '0;
                        err_n    = 1'b1;
                        state_n  = DONE;
                    end
                end
            end
            INT_DIGITS: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (is_digit) begin
                        acc_n = (acc << 3) + (acc << 1) + digit;
                    end else begin
                        result_n = neg ? ~acc + 32'd1 : acc;
                        state_n  = DONE;
                    end
                end
            end
            DONE: begin
                err_n   = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            acc    <= '0;
            neg    <= 1'b0;
            err    <= 1'b0;
            result <= '0;
        end else begin
            state  <= state_n;
            acc    <= acc_n;
            neg    <= neg_n;
            err    <= err_n;
            result <= result_n;
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: tb/tb_syscall_input_unit.sv
// tb_syscall_input_unit: directed stimulus with a queue/token model checked every cycle,
// plus literal expectations on results and stall lengths.
module tb_syscall_input_unit;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        is_syscall = 1'b0;
    logic [31:0] syscall_funct = '0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready, stall, result_valid, parse_error;
    logic [31:0] result;

    int total = 0;
    int bad = 0;
    bit chk_en = 0;

    always #5 clock = ~clock;

    syscall_input_unit dut (
        .clock(clock), .reset(reset), .is_syscall(is_syscall), .syscall_funct(syscall_funct),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .stall(stall),
        .result_valid(result_valid), .result(result), .parse_error(parse_error)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: byte queue plus the token text of the integer being read
    logic [7:0]  m_q[$];
    logic [7:0]  tok[$];
    int          m_busy = 0;
    bit          m_done = 0, m_err = 0, m_started = 0, m_had, m_pu;
    logic [31:0] m_res = '0;
    logic [7:0]  m_b;

    function automatic bit is_dig(input logic [7:0] b);
        return b >= "0" && b <= "9";
    endfunction

    function automatic bit is_ws(input logic [7:0] b);
        return b == 8'h20 || b == 8'h09 || b == 8'h0A || b == 8'h0D;
    endfunction

    function automatic logic [31:0] tok_value();
        longint v = 0;
        bit n = 0;
        foreach (tok[i]) begin
            if (tok[i] == "-") n = 1;
            else if (is_dig(tok[i])) v = (v * 10 + longint'(tok[i] - "0")) % 64'd4294967296;
        end
        return n ? 32'(-v) : 32'(v);
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_q.delete();
            m_busy = 0;
            m_done = 0;
            m_err  = 0;
            m_res  = '0;
        end else begin
            m_pu  = in_valid && m_q.size() < 8;
            m_had = m_q.size() > 0;
            if (m_done) begin
                m_done = 0;
                m_err  = 0;
            end else if (m_busy == 0) begin
                if (is_syscall && syscall_funct == 12) m_busy = 1;
                else if (is_syscall && syscall_funct == 5) begin
                    m_busy = 5;
                    tok.delete();
                    m_started = 0;
                end
            end else if (m_had) begin
                m_b = m_q.pop_front();
                if (m_busy == 1) begin
                    m_res = {24'd0, m_b};
                    m_busy = 0;
                    m_done = 1;
                end else if (!m_started) begin
                    if (m_b == "+" || m_b == "-" || is_dig(m_b)) begin
                        tok.push_back(m_b);
                        m_started = 1;
                    end else if (!is_ws(m_b)) begin
                        m_res = '0;
                        m_err = 1;
                        m_busy = 0;
                        m_done = 1;
                    end
                end else if (is_dig(m_b)) begin
                    tok.push_back(m_b);
                end else begin
                    m_res = tok_value();
                    m_busy = 0;
                    m_done = 1;
                end
            end
            if (m_pu) m_q.push_back(in_data);
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("in_ready", in_ready, !reset && m_q.size() < 8);
            chk("stall", stall, !reset && (m_busy != 0 ||
                (!m_done && is_syscall && (syscall_funct == 5 || syscall_funct == 12))));
            chk("result_valid", result_valid, !reset && m_done);
            chk("parse_error", parse_error, !reset && m_done && m_err);
            chk("result", result, m_res);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_str(input string s);
        bit a;
        for (int i = 0; i < s.len(); i++) begin
            in_valid = 1'b1;
            in_data  = s[i];
            for (int k = 0; k < 100; k++) begin
                #1;
                a = in_ready;
                @(posedge clock);
                #1;
                if (a) break;
            end
        end
        in_valid = 1'b0;
    endtask

    int          st;
    logic [31:0] r;
    logic        pe;

    task automatic do_sys(input logic [31:0] f, output int s_cnt, output logic [31:0] res, output logic perr);
        bit got = 0;
        s_cnt = 0;
        res = 32'hDEADBEEF;
        perr = 1'b0;
        syscall_funct = f;
        is_syscall = 1'b1;
        for (int i = 0; i < 300; i++) begin
            #1;
            if (result_valid) begin
                res = result;
                perr = parse_error;
                got = 1;
                break;
            end
            if (stall) s_cnt++;
            @(posedge clock);
            #1;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL syscall_timeout: got no result_valid expected a pulse for funct %0d", f);
        end
        @(posedge clock);
        #1;
        is_syscall = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid = 1'b1;
        in_data  = 8'h55;
        tick();
        chk_en = 1;
        tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_stall", stall, 0);
        chk("rst_result", result, 0);
        chk("rst_result_valid", result_valid, 0);
        reset = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        tick();

        push_str("A");
        do_sys(12, st, r, pe);
        chk("char_stall_cycles", st, 2);
        chk("char_result", r, 32'h41);

        push_str(" -123\n");
        do_sys(5, st, r, pe);
        chk("neg_stall_cycles", st, 7);
        chk("neg_result", r, 32'hFFFFFF85);
        chk("neg_parse_error", pe, 0);

        fork
            do_sys(5, st, r, pe);
            begin
                repeat (5) tick();
                push_str("7");
                repeat (2) tick();
                push_str("\n");
            end
        join
        chk("starved_stall_cycles", st, 10);
        chk("starved_result", r, 7);

        push_str("ABCDEFGH");
        chk("full_in_ready", in_ready, 0);
        in_valid = 1'b1;
        in_data  = "I";
        tick();
        in_valid = 1'b0;
        do_sys(12, st, r, pe);
        chk("full_first_char", r, 32'h41);
        chk("full_in_ready_back", in_ready, 1);
        for (int i = 0; i < 7; i++) begin
            do_sys(12, st, r, pe);
            chk("drain_char", r, 32'h42 + i);
        end

        fork
            push_str("4294967297\n");
            do_sys(5, st, r, pe);
        join
        chk("wrap_result", r, 1);

        push_str("x");
        do_sys(5, st, r, pe);
        chk("err_result", r, 0);
        chk("err_parse_error", pe, 1);
        tick();
        chk("err_pulse_ends", parse_error, 0);

        push_str("Q");
        syscall_funct = 1;
        is_syscall = 1'b1;
        #1;
        chk("other_funct_stall", stall, 0);
        tick();
        is_syscall = 1'b0;
        do_sys(12, st, r, pe);
        chk("other_funct_no_pop", r, 32'h51);

        push_str("5");
        syscall_funct = 5;
        is_syscall = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        is_syscall = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        chk("midrst_result", result, 0);
        push_str("Z");
        do_sys(12, st, r, pe);
        chk("after_midrst_char", r, 32'h5A);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
